// File: rtl/uart_rx_word16_pkg.sv
// Shared definitions for the 16-bit UART receive path: FSM state
// encodings and helpers that derive bit-period and counter widths.
package uart_pkg;

    // Byte FSM encoding (one 8N1 frame)
    localparam logic [1:0] BYTE_IDLE  = 2'd0;
    localparam logic [1:0] BYTE_START = 2'd1;
    localparam logic [1:0] BYTE_DATA  = 2'd2;
    localparam logic [1:0] BYTE_STOP  = 2'd3;

    // Word FSM encoding (pairing of low and high byte)
    localparam logic [0:0] WORD_WAIT_LO = 1'b0;
    localparam logic [0:0] WORD_WAIT_HI = 1'b1;

    // Clock cycles per bit, truncated toward zero
    function automatic int unsigned bps_cnt_calc(input int unsigned clk_freq,
                                                 input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Width of a counter that must hold values 0 .. max_val-1 (never below 1)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        if (max_val < 32'd2) begin
            w = 32'd1;
        end else begin
            w = $clog2(max_val);
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_word16_recv.sv
// Single-byte 8N1 receiver: synchronises the RXD pin, finds the start edge,
// samples each bit at its middle and reports a good or badly-framed byte.
// byte_done / byte_err are decoded from registered state so the word layer
// can react in the very cycle the stop bit is sampled.
module uart_recv
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115_200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       byte_err,
    output logic       busy
);

    localparam int unsigned BPS_CNT  = bps_cnt_calc(CLK_FREQ, UART_BPS);
    localparam int unsigned HALF_CNT = BPS_CNT / 32'd2;
    localparam int unsigned CNT_W    = cnt_width(BPS_CNT);

    // Start bit is checked on the BPS_CNT/2-th cycle spent in START, data and
    // stop bits one full bit period after the previous sample.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 32'd1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 32'd1);

    logic             rxd_meta_q;
    logic             rxd_sync_q;
    logic             rxd_dly_q;
    logic             start_edge_s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             byte_done_s;
    logic             byte_err_s;

    // Two-stage synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_dly_q  <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_dly_q  <= rxd_sync_q;
        end
    end

    // A start edge is the synchronised line going from 1 to 0
    assign start_edge_s = rxd_dly_q & ~rxd_sync_q;

    // Byte FSM next-state, bit timing and shift register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_s = 1'b0;
        byte_err_s  = 1'b0;
        case (state_q)
            BYTE_IDLE: begin
                cnt_d = '0;
                if (start_edge_s) begin
                    state_d = BYTE_START;
                end else begin
                    state_d = BYTE_IDLE;
                end
            end
            BYTE_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // A line already back high at mid-start was only a glitch
                    if (rxd_sync_q) begin
                        state_d = BYTE_IDLE;
                    end else begin
                        state_d = BYTE_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = BYTE_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    // Back to IDLE at mid-stop so an early next start is not missed
                    cnt_d   = '0;
                    state_d = BYTE_IDLE;
                    if (rxd_sync_q) begin
                        byte_done_s = 1'b1;
                    end else begin
                        byte_err_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = BYTE_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != BYTE_IDLE);
    end

    // Byte FSM state registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= BYTE_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
        end
    end

    assign byte_data = shift_q;
    assign byte_done = byte_done_s;
    assign byte_err  = byte_err_s;
    assign busy      = busy_q;

endmodule

// File: rtl/uart_rx_word16.sv
// 16-bit word receiver: pairs two 8N1 bytes (low byte first) into one word.
// A pending low byte is discarded on a framing error or when the high byte
// does not start within TIMEOUT_BITS bit times of the low byte's stop bit.
module uart_rx_word16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned UART_BPS     = 115_200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_rxd,
    output logic [15:0] data_16,
    output logic        data_valid,
    output logic        frame_err,
    output logic        word_timeout,
    output logic        uart_rx_busy
);

    localparam int unsigned BPS_CNT = bps_cnt_calc(CLK_FREQ, UART_BPS);
    localparam int unsigned TMO_CNT = TIMEOUT_BITS * BPS_CNT;
    localparam int unsigned TMO_W   = cnt_width(TMO_CNT);

    // Expiry happens on the TMO_CNT-th idle cycle spent waiting for the high byte
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CNT - 32'd1);

    logic [7:0]       rx_byte_s;
    logic             rx_done_s;
    logic             rx_err_s;
    logic             rx_busy_s;

    logic [0:0]       word_state_q, word_state_d;
    logic [7:0]       lo_byte_q, lo_byte_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]      data_16_q, data_16_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             word_timeout_q, word_timeout_d;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_recv (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .byte_data (rx_byte_s),
        .byte_done (rx_done_s),
        .byte_err  (rx_err_s),
        .busy      (rx_busy_s)
    );

    // Word FSM: byte pairing, inter-byte timeout and output pulse generation
    always_comb begin
        word_state_d   = word_state_q;
        lo_byte_d      = lo_byte_q;
        tmo_cnt_d      = tmo_cnt_q;
        data_16_d      = data_16_q;
        data_valid_d   = 1'b0;
        frame_err_d    = 1'b0;
        word_timeout_d = 1'b0;
        if (rx_err_s) begin
            // Bad stop bit: abandon any half-built word
            frame_err_d  = 1'b1;
            word_state_d = WORD_WAIT_LO;
            lo_byte_d    = 8'h00;
            tmo_cnt_d    = '0;
        end else begin
            case (word_state_q)
                WORD_WAIT_LO: begin
                    tmo_cnt_d = '0;
                    if (rx_done_s) begin
                        lo_byte_d    = rx_byte_s;
                        word_state_d = WORD_WAIT_HI;
                    end else begin
                        word_state_d = WORD_WAIT_LO;
                    end
                end
                WORD_WAIT_HI: begin
                    // Completion is checked before expiry so it wins a tie
                    if (rx_done_s) begin
                        data_16_d    = {rx_byte_s, lo_byte_q};
                        data_valid_d = 1'b1;
                        word_state_d = WORD_WAIT_LO;
                        tmo_cnt_d    = '0;
                    end else if (!rx_busy_s) begin
                        if (tmo_cnt_q == TMO_LAST) begin
                            word_timeout_d = 1'b1;
                            word_state_d   = WORD_WAIT_LO;
                            lo_byte_d      = 8'h00;
                            tmo_cnt_d      = '0;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        end
                    end else begin
                        // High byte in flight: freeze the gap counter
                        tmo_cnt_d = tmo_cnt_q;
                    end
                end
                default: begin
                    word_state_d = WORD_WAIT_LO;
                    tmo_cnt_d    = '0;
                end
            endcase
        end
    end

    // Word FSM registers and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_state_q   <= WORD_WAIT_LO;
            lo_byte_q      <= 8'h00;
            tmo_cnt_q      <= '0;
            data_16_q      <= 16'h0000;
            data_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            word_timeout_q <= 1'b0;
        end else begin
            word_state_q   <= word_state_d;
            lo_byte_q      <= lo_byte_d;
            tmo_cnt_q      <= tmo_cnt_d;
            data_16_q      <= data_16_d;
            data_valid_q   <= data_valid_d;
            frame_err_q    <= frame_err_d;
            word_timeout_q <= word_timeout_d;
        end
    end

    assign data_16      = data_16_q;
    assign data_valid   = data_valid_q;
    assign frame_err    = frame_err_q;
    assign word_timeout = word_timeout_q;
    assign uart_rx_busy = rx_busy_s | (word_state_q == WORD_WAIT_HI);

endmodule
